// File: rtl/branch_info_queue.sv
// branch_info_queue: in-order queue of in-flight branch predictions; resolves out of order by tag,
// retires in program order to the predictor update port and squashes younger entries on a mispredict.
module branch_info_queue #(
    parameter int DEPTH    = 8,
    parameter int GHR_BITS = 10,
    parameter int TAG_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    input  logic [31:0]         alloc_pc,
    input  logic                alloc_pred_taken,
    input  logic [GHR_BITS-1:0] alloc_ghr,
    output logic [TAG_BITS-1:0] alloc_tag,
    input  logic                resolve_valid,
    input  logic [TAG_BITS-1:0] resolve_tag,
    input  logic                resolve_taken,
    output logic                update_valid,
    output logic [31:0]         update_pc,
    output logic                update_taken,
    output logic [GHR_BITS-1:0] update_ghr,
    output logic                mispredict_valid,
    output logic [GHR_BITS-1:0] mispredict_ghr
);
    localparam int CW = TAG_BITS + 1;

    logic                valid_q    [DEPTH];
    logic                valid_d    [DEPTH];
    logic                resolved_q [DEPTH];
    logic                resolved_d [DEPTH];
    logic                taken_q    [DEPTH];
    logic                taken_d    [DEPTH];
    logic [31:0]         pc_q       [DEPTH];
    logic                pred_q     [DEPTH];
    logic [GHR_BITS-1:0] ghr_q      [DEPTH];
    logic [TAG_BITS-1:0] head_q, head_d, tail_q, tail_d, rt_off;
    logic [CW-1:0]       count_q, count_d;
    logic                mp_valid_q, mp_valid_d;
    logic [GHR_BITS-1:0] mp_ghr_q, mp_ghr_d;
    logic                retire, res_ok, mp, fire;

    assign alloc_ready      = count_q != CW'(DEPTH);
    assign alloc_tag        = tail_q;
    assign retire           = valid_q[head_q] & resolved_q[head_q];
    assign res_ok           = resolve_valid & valid_q[resolve_tag] & ~resolved_q[resolve_tag];
    assign mp               = res_ok & (resolve_taken != pred_q[resolve_tag]);
    // A wrong-path allocation arriving with a mispredict is dropped.
    assign fire             = alloc_valid & alloc_ready & ~mp;
    assign rt_off           = resolve_tag - head_q;
    assign update_valid     = retire;
    assign update_pc        = retire ? pc_q[head_q] : '0;
    assign update_taken     = retire ? taken_q[head_q] : 1'b0;
    assign update_ghr       = retire ? ghr_q[head_q] : '0;
    assign mispredict_valid = mp_valid_q;
    assign mispredict_ghr   = mp_ghr_q;

    always_comb begin
        valid_d    = valid_q;
        resolved_d = resolved_q;
        taken_d    = taken_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        mp_valid_d = mp;
        mp_ghr_d   = mp ? {ghr_q[resolve_tag][GHR_BITS-2:0], resolve_taken} : mp_ghr_q;
        if (retire) begin
            valid_d[head_q]    = 1'b0;
            resolved_d[head_q] = 1'b0;
            head_d             = head_q + 1'b1;
        end
        if (res_ok) begin
            resolved_d[resolve_tag] = 1'b1;
            taken_d[resolve_tag]    = resolve_taken;
        end
        if (mp) begin
            // Age is the distance from head; anything further than the resolving entry is younger.
            for (int i = 0; i < DEPTH; i++)
                if (TAG_BITS'(TAG_BITS'(i) - head_q) > rt_off) valid_d[i] = 1'b0;
            tail_d  = resolve_tag + 1'b1;
            count_d = {1'b0, rt_off} + CW'(1) - CW'(retire);
        end else begin
            if (fire) begin
                valid_d[tail_q]    = 1'b1;
                resolved_d[tail_q] = 1'b0;
                tail_d             = tail_q + 1'b1;
            end
            count_d = count_q + CW'(fire) - CW'(retire);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]    <= 1'b0;
                resolved_q[i] <= 1'b0;
                taken_q[i]    <= 1'b0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            mp_valid_q <= 1'b0;
            mp_ghr_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            mp_valid_q <= mp_valid_d;
            mp_ghr_q   <= mp_ghr_d;
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        if (fire) begin
            pc_q[tail_q]   <= alloc_pc;
            pred_q[tail_q] <= alloc_pred_taken;
            ghr_q[tail_q]  <= alloc_ghr;
        end
    end
endmodule

// File: tb/tb_branch_info_queue.sv
// tb_branch_info_queue: directed scenario tests for branch_info_queue.
module tb_branch_info_queue;
    logic        clk = 1'b0, rst = 1'b0;
    logic        alloc_valid = 1'b0, alloc_ready, alloc_pred_taken = 1'b0;
    logic [31:0] alloc_pc = '0, update_pc;
    logic [9:0]  alloc_ghr = '0, update_ghr, mispredict_ghr;
    logic [2:0]  alloc_tag, resolve_tag = '0;
    logic        resolve_valid = 1'b0, resolve_taken = 1'b0;
    logic        update_valid, update_taken, mispredict_valid;
    int          n_checks = 0, n_fail = 0;

    branch_info_queue dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_pred_taken(alloc_pred_taken), .alloc_ghr(alloc_ghr), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_ghr(update_ghr), .mispredict_valid(mispredict_valid), .mispredict_ghr(mispredict_ghr)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        alloc_valid = 1'b0; resolve_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); idle_inputs(); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic pred, input logic [9:0] ghr);
        @(negedge clk);
        idle_inputs();
        alloc_valid = 1'b1; alloc_pc = pc; alloc_pred_taken = pred; alloc_ghr = ghr;
    endtask

    task automatic resolve(input logic [2:0] tag, input logic taken);
        @(negedge clk);
        idle_inputs();
        resolve_valid = 1'b1; resolve_tag = tag; resolve_taken = taken;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", alloc_ready); end
        n_checks++; if (alloc_tag !== 3'd0) begin n_fail++; $display("FAIL rst_tag got %0d want 0", alloc_tag); end
        n_checks++; if (update_valid !== 1'b0) begin n_fail++; $display("FAIL rst_upd got %b want 0", update_valid); end
        n_checks++; if (mispredict_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mp got %b want 0", mispredict_valid); end
        n_checks++; if (mispredict_ghr !== 10'h0) begin n_fail++; $display("FAIL rst_mpghr got %h want 0", mispredict_ghr); end
        @(negedge clk); rst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0 || update_valid !== 1'b0 || mispredict_valid !== 1'b0)
            begin n_fail++; $display("FAIL idle got ready=%b tag=%0d upd=%b mp=%b want 1 0 0 0", alloc_ready, alloc_tag, update_valid, mispredict_valid); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc(32'h1000 + 32'(4 * i), 1'b0, 10'(i));
            n_checks++; if (alloc_tag !== 3'(i)) begin n_fail++; $display("FAIL fill_tag got %0d want %0d", alloc_tag, i); end
        end
        alloc(32'h2000, 1'b0, 10'h3ff);
        n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", alloc_ready); end
        @(negedge clk); idle_inputs();
        n_checks++; if (alloc_ready !== 1'b0 || alloc_tag !== 3'd0) begin n_fail++; $display("FAIL ninth_ignored got ready=%b tag=%0d want 0 0", alloc_ready, alloc_tag); end
        resolve(3'd0, 1'b0);
        @(negedge clk); idle_inputs();
        n_checks++; if (update_valid !== 1'b1 || update_pc !== 32'h1000 || update_taken !== 1'b0)
            begin n_fail++; $display("FAIL fill_retire got v=%b pc=%h t=%b want 1 1000 0", update_valid, update_pc, update_taken); end
        n_checks++; if (mispredict_valid !== 1'b0) begin n_fail++; $display("FAIL fill_mp got %b want 0", mispredict_valid); end
        @(negedge clk);
        n_checks++; if (update_valid !== 1'b0 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0)
            begin n_fail++; $display("FAIL after_retire got v=%b ready=%b tag=%0d want 0 1 0", update_valid, alloc_ready, alloc_tag); end
    endtask

    task automatic test_ooo();
        do_reset();
        alloc(32'h100, 1'b1, 10'h011);
        alloc(32'h104, 1'b1, 10'h022);
        alloc(32'h108, 1'b1, 10'h033);
        resolve(3'd2, 1'b1);
        @(negedge clk); idle_inputs();
        n_checks++; if (update_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_early got %b want 0", update_valid); end
        resolve(3'd0, 1'b1);
        @(negedge clk); idle_inputs();
        n_checks++; if (update_valid !== 1'b1 || update_pc !== 32'h100 || update_ghr !== 10'h011)
            begin n_fail++; $display("FAIL ooo_t0 got v=%b pc=%h ghr=%h want 1 100 011", update_valid, update_pc, update_ghr); end
        resolve(3'd1, 1'b1);
        n_checks++; if (update_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wait got %b want 0", update_valid); end
        @(negedge clk); idle_inputs();
        n_checks++; if (update_valid !== 1'b1 || update_pc !== 32'h104 || update_ghr !== 10'h022 || update_taken !== 1'b1)
            begin n_fail++; $display("FAIL ooo_t1 got v=%b pc=%h ghr=%h want 1 104 022", update_valid, update_pc, update_ghr); end
        @(negedge clk);
        n_checks++; if (update_valid !== 1'b1 || update_pc !== 32'h108 || update_ghr !== 10'h033)
            begin n_fail++; $display("FAIL ooo_t2 got v=%b pc=%h ghr=%h want 1 108 033", update_valid, update_pc, update_ghr); end
        @(negedge clk);
        n_checks++; if (update_valid !== 1'b0 || alloc_tag !== 3'd3 || alloc_ready !== 1'b1)
            begin n_fail++; $display("FAIL ooo_done got v=%b tag=%0d ready=%b want 0 3 1", update_valid, alloc_tag, alloc_ready); end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 5; i++)
            alloc(32'h200 + 32'(4 * i), i != 1, i == 1 ? 10'h155 : 10'(i));
        resolve(3'd1, 1'b1);
        alloc_valid = 1'b1; alloc_pc = 32'h300; alloc_pred_taken = 1'b1; alloc_ghr = 10'h0;
        n_checks++; if (alloc_tag !== 3'd5) begin n_fail++; $display("FAIL mp_pre_tag got %0d want 5", alloc_tag); end
        @(negedge clk); idle_inputs();
        n_checks++; if (mispredict_valid !== 1'b1 || mispredict_ghr !== 10'h2AB)
            begin n_fail++; $display("FAIL mp_pulse got v=%b ghr=%h want 1 2ab", mispredict_valid, mispredict_ghr); end
        n_checks++; if (alloc_tag !== 3'd2 || update_valid !== 1'b0)
            begin n_fail++; $display("FAIL mp_tail got tag=%0d upd=%b want 2 0", alloc_tag, update_valid); end
        @(negedge clk);
        n_checks++; if (mispredict_valid !== 1'b0) begin n_fail++; $display("FAIL mp_one_cycle got %b want 0", mispredict_valid); end
        resolve(3'd3, 1'b0);
        @(negedge clk); idle_inputs();
        n_checks++; if (mispredict_valid !== 1'b0 || alloc_tag !== 3'd2)
            begin n_fail++; $display("FAIL squashed_ignored got mp=%b tag=%0d want 0 2", mispredict_valid, alloc_tag); end
        resolve(3'd0, 1'b1);
        @(negedge clk); idle_inputs();
        n_checks++; if (update_valid !== 1'b1 || update_pc !== 32'h200) begin n_fail++; $display("FAIL mp_ret0 got v=%b pc=%h want 1 200", update_valid, update_pc); end
        @(negedge clk);
        n_checks++; if (update_valid !== 1'b1 || update_pc !== 32'h204 || update_taken !== 1'b1 || update_ghr !== 10'h155)
            begin n_fail++; $display("FAIL mp_ret1 got v=%b pc=%h t=%b ghr=%h want 1 204 1 155", update_valid, update_pc, update_taken, update_ghr); end
        @(negedge clk);
        n_checks++; if (update_valid !== 1'b0 || alloc_ready !== 1'b1 || alloc_tag !== 3'd2)
            begin n_fail++; $display("FAIL mp_drained got v=%b ready=%b tag=%0d want 0 1 2", update_valid, alloc_ready, alloc_tag); end
    endtask

    // Entry j: allocated in cycle j, resolved in cycle j+2, visible on update in cycle j+3.
    task automatic test_wrap();
        int retired = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c < 20) begin
                alloc_valid = 1'b1; alloc_pc = 32'h4000 + 32'(4 * c); alloc_pred_taken = c[0]; alloc_ghr = 10'(3 * c);
                n_checks++; if (alloc_tag !== 3'(c % 8) || alloc_ready !== 1'b1)
                    begin n_fail++; $display("FAIL wrap_tag c=%0d got %0d/%b want %0d/1", c, alloc_tag, alloc_ready, c % 8); end
            end
            if (c >= 2 && c < 22) begin
                resolve_valid = 1'b1; resolve_tag = 3'((c - 2) % 8); resolve_taken = c[0];
            end
            if (c >= 3 && c < 23) begin
                n_checks++;
                if (update_valid !== 1'b1 || update_pc !== 32'h4000 + 32'(4 * (c - 3)) || update_ghr !== 10'(3 * (c - 3)) || update_taken !== c[0] ^ 1'b1)
                    begin n_fail++; $display("FAIL wrap_ret c=%0d got v=%b pc=%h ghr=%h want pc=%h", c, update_valid, update_pc, update_ghr, 32'h4000 + 32'(4 * (c - 3))); end
                else retired++;
            end else begin
                n_checks++; if (update_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_idle c=%0d got %b want 0", c, update_valid); end
            end
            n_checks++; if (mispredict_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_mp c=%0d got %b want 0", c, mispredict_valid); end
        end
        n_checks++; if (retired !== 20) begin n_fail++; $display("FAIL wrap_count got %0d want 20", retired); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) alloc(32'h500 + 32'(4 * i), 1'b0, 10'(i));
        resolve(3'd0, 1'b0);
        @(negedge clk); idle_inputs();
        n_checks++; if (update_valid !== 1'b1 || alloc_tag !== 3'd5) begin n_fail++; $display("FAIL ar_pre got v=%b tag=%0d want 1 5", update_valid, alloc_tag); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (update_valid !== 1'b0 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0 || update_pc !== 32'h0)
            begin n_fail++; $display("FAIL ar_immediate got v=%b ready=%b tag=%0d pc=%h want 0 1 0 0", update_valid, alloc_ready, alloc_tag, update_pc); end
        @(negedge clk); rst = 1'b1;
        alloc(32'h600, 1'b1, 10'h1);
        n_checks++; if (alloc_tag !== 3'd0 || update_valid !== 1'b0) begin n_fail++; $display("FAIL ar_after got tag=%0d v=%b want 0 0", alloc_tag, update_valid); end
        @(negedge clk); idle_inputs();
        n_checks++; if (alloc_tag !== 3'd1) begin n_fail++; $display("FAIL ar_next got %0d want 1", alloc_tag); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_ooo();
        test_mispredict();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
